// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register offsets,
// CTRL/STATUS bit positions, FSM state encoding and the length clamp.
package led_seq_pkg;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_PERIOD = 4'd1;
  localparam logic [3:0] REG_STATUS = 4'd2;
  localparam logic [3:0] REG_LENGTH = 4'd3;
  localparam logic [3:0] REG_TABLE  = 4'd8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQEN   = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_COUNT = 2'd2
  } seq_state_e;

  // LENGTH=0 behaves as 1; anything beyond the table depth wraps at the table end.
  function automatic logic [3:0] eff_length(input logic [3:0] len, input logic [3:0] steps);
    if (len == 4'd0)
      return 4'd1;
    else if (len > steps)
      return steps;
    else
      return len;
  endfunction

endpackage

// File: rtl/led_seq_timer.sv
// Loadable down-counter that paces the dwell between LED steps.
// Load has priority over counting; the count stops at zero.
module led_seq_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                en,
  output logic                zero
);

  logic [PERIOD_W-1:0] cnt;

  // Counter register: reload, or step down towards zero while enabled.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nios2_system_led_sequencer.sv
// Autonomous LED pattern player. The CPU programs a pattern table, dwell
// period and step count through the slave port; the block then drives the
// LED PIO s1 port through its own master, one pattern per step.
// Optional feature macro: LED_SEQ_IRQ_EN adds the irq output and CTRL.IRQEN.
module nios2_system_led_sequencer
  import led_seq_pkg::*;
#(
  parameter int STEPS    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int IDX_W = $clog2(STEPS);

  seq_state_e          state, state_nx;
  logic                ctrl_en, ctrl_oneshot, ctrl_irqen;
  logic [PERIOD_W-1:0] period;
  logic [3:0]          length;
  logic [7:0]          pat_tbl [STEPS];
  logic [IDX_W-1:0]    idx;
  logic                done;
  logic [7:0]          pattern;

  logic                s_wr;
  logic                tbl_hit;
  logic [IDX_W-1:0]    tbl_sel;
  logic [IDX_W-1:0]    pat_sel;
  logic [3:0]          last_idx;
  logic                at_last;

  logic                tmr_load, tmr_en, tmr_zero;
  logic                idx_clr, idx_inc, pat_ld, os_done;
  logic                unused_wdata;

  assign s_wr     = s_chipselect & ~s_write_n;
  assign tbl_hit  = s_address[3] && ({1'b0, s_address[2:0]} < 4'(STEPS));
  assign tbl_sel  = s_address[IDX_W-1:0];
  assign last_idx = eff_length(length, 4'(STEPS)) - 4'd1;
  assign at_last  = (4'(idx) == last_idx);
  assign pat_sel  = (state == ST_IDLE) ? '0 : idx;
  assign unused_wdata = ^s_writedata;

  led_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (period),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Next state, master strobes and datapath control strobes.
  always_comb begin
    state_nx     = state;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    idx_clr      = 1'b0;
    idx_inc      = 1'b0;
    pat_ld       = 1'b0;
    os_done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_en) begin
          idx_clr  = 1'b1;
          pat_ld   = 1'b1;
          state_nx = ST_WRITE;
        end
      end
      ST_WRITE: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        if (!m_waitrequest) begin
          if (at_last) begin
            if (ctrl_oneshot) os_done = 1'b1;
            else              idx_clr = 1'b1;
          end else begin
            idx_inc = 1'b1;
          end
          // A stop request is honoured only once the write has been taken.
          if (os_done || !ctrl_en) begin
            state_nx = ST_IDLE;
          end else begin
            tmr_load = 1'b1;
            state_nx = ST_COUNT;
          end
        end
      end
      ST_COUNT: begin
        if (!ctrl_en) begin
          state_nx = ST_IDLE;
        end else if (tmr_zero) begin
          pat_ld   = 1'b1;
          state_nx = ST_WRITE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Control registers, pattern table, step index, DONE flag and output pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      period       <= '0;
      length       <= 4'(STEPS);
      for (int i = 0; i < STEPS; i++) pat_tbl[i] <= '0;
      idx          <= '0;
      done         <= 1'b0;
      pattern      <= '0;
    end else begin
      if (s_wr) begin
        case (s_address)
          REG_CTRL: begin
            ctrl_en      <= s_writedata[CTRL_EN];
            ctrl_oneshot <= s_writedata[CTRL_ONESHOT];
          end
          REG_PERIOD: period <= s_writedata[PERIOD_W-1:0];
          REG_STATUS: if (s_writedata[STAT_DONE]) done <= 1'b0;
          REG_LENGTH: length <= s_writedata[3:0];
          default:    if (tbl_hit) pat_tbl[tbl_sel] <= s_writedata[7:0];
        endcase
      end
      // Sequencer-side updates come last so a completing one-shot wins.
      if (os_done) begin
        ctrl_en <= 1'b0;
        done    <= 1'b1;
      end
      if (idx_clr)
        idx <= '0;
      else if (idx_inc)
        idx <= idx + 1'b1;
      if (pat_ld)
        pattern <= pat_tbl[pat_sel];
    end
  end

`ifdef LED_SEQ_IRQ_EN
  // Interrupt enable bit lives in CTRL alongside EN/ONESHOT.
  always_ff @(posedge clk) begin
    if (reset)
      ctrl_irqen <= 1'b0;
    else if (s_wr && (s_address == REG_CTRL))
      ctrl_irqen <= s_writedata[CTRL_IRQEN];
  end

  assign irq = done & ctrl_irqen;
`else
  assign ctrl_irqen = 1'b0;
`endif

  // Zero-wait-state register read mux.
  always_comb begin
    s_readdata = '0;
    case (s_address)
      REG_CTRL: begin
        s_readdata[CTRL_EN]      = ctrl_en;
        s_readdata[CTRL_ONESHOT] = ctrl_oneshot;
        s_readdata[CTRL_IRQEN]   = ctrl_irqen;
      end
      REG_PERIOD: s_readdata[PERIOD_W-1:0] = period;
      REG_STATUS: begin
        s_readdata[STAT_BUSY] = (state != ST_IDLE);
        s_readdata[STAT_DONE] = done;
        s_readdata[STAT_IDX_LSB +: 3] = 3'(idx);
      end
      REG_LENGTH: s_readdata[3:0] = length;
      default:    if (tbl_hit) s_readdata[7:0] = pat_tbl[tbl_sel];
    endcase
  end

  assign m_address   = 2'b00;
  assign m_writedata = {24'b0, pattern};

endmodule

// File: tb/tb_nios2_system_led_sequencer.sv
// Testbench for nios2_system_led_sequencer: directed register programming,
// expected PIO writes (data and cycle of acceptance) queued in a scoreboard
// and checked by an independent monitor on the falling clock edge.
module tb_nios2_system_led_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  s_address = '0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
`endif

  nios2_system_led_sequencer #(.STEPS(8), .PERIOD_W(24)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_address     (s_address),
    .s_chipselect  (s_chipselect),
    .s_write_n     (s_write_n),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Monitor: holds under stall, checks every accepted PIO write against the queue.
  always @(negedge clk) begin
    if (!reset && m_chipselect && !m_write_n) begin
      if (m_waitrequest) begin
        if (sb.size() != 0)
          check("stall_hold", m_writedata, {24'b0, sb[0].data});
      end else if (sb.size() == 0) begin
        check("unexpected_write", m_writedata, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_data", m_writedata, {24'b0, e.data});
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
        check("wr_addr", {30'b0, m_address}, 32'd0);
      end
    end
  end

  // All tasks below assume they are entered 1 time unit after a rising edge.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    s_address    = a;
    s_writedata  = d;
    s_chipselect = 1'b1;
    s_write_n    = 1'b0;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
  endtask

  task automatic chk_read(input string name, input logic [3:0] a, input logic [31:0] exp);
    s_address = a;
    #1;
    check(name, s_readdata, exp);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_cs", {31'b0, m_chipselect}, 32'd0);
    check("rst_wn", {31'b0, m_write_n}, 32'd1);
    check("rst_wdata", m_writedata, 32'd0);
    check("rst_maddr", {30'b0, m_address}, 32'd0);
    chk_read("rst_ctrl", 4'd0, 32'd0);
    chk_read("rst_period", 4'd1, 32'd0);
    chk_read("rst_status", 4'd2, 32'd0);
    chk_read("rst_length", 4'd3, 32'd8);
    chk_read("rst_tbl7", 4'd15, 32'd0);
`ifdef LED_SEQ_IRQ_EN
    check("rst_irq", {31'b0, irq}, 32'd0);
`endif
    cpu_write(4'd4, 32'hFFFF_FFFF);
    chk_read("unmapped", 4'd4, 32'd0);

    // Basic loop: 01,02,04,08 at PERIOD=3 -> 5-cycle spacing
    cpu_write(4'd8,  32'h01);
    cpu_write(4'd9,  32'h02);
    cpu_write(4'd10, 32'h04);
    cpu_write(4'd11, 32'h08);
    cpu_write(4'd3,  32'd4);
    cpu_write(4'd1,  32'd3);
    chk_read("period_rb", 4'd1, 32'd3);
    t = cyc;
    push(8'h01, t + 2);
    push(8'h02, t + 7);
    push(8'h04, t + 12);
    push(8'h08, t + 17);
    push(8'h01, t + 22);
    cpu_write(4'd0, 32'h1);
    goto(t + 4);
    chk_read("busy_run", 4'd2, 32'h11);
    cpu_write(4'd0, 32'h1);
    goto(t + 23);
    cpu_write(4'd0, 32'h0);
    wait_drain("loop_drain", 40);
    idle(12);
    chk_read("loop_stopped", 4'd2, 32'h10);

    // One-shot: AA,55 then EN cleared, DONE set
    cpu_write(4'd8, 32'hAA);
    cpu_write(4'd9, 32'h55);
    cpu_write(4'd3, 32'd2);
    t = cyc;
    push(8'hAA, t + 2);
    push(8'h55, t + 7);
`ifdef LED_SEQ_IRQ_EN
    cpu_write(4'd0, 32'h7);
`else
    cpu_write(4'd0, 32'h7);
`endif
    wait_drain("oneshot_drain", 40);
    idle(15);
`ifdef LED_SEQ_IRQ_EN
    chk_read("oneshot_ctrl", 4'd0, 32'h6);
    check("oneshot_irq", {31'b0, irq}, 32'd1);
`else
    chk_read("oneshot_ctrl", 4'd0, 32'h2);
`endif
    chk_read("oneshot_status", 4'd2, 32'h12);
    cpu_write(4'd2, 32'h2);
    chk_read("done_clear", 4'd2, 32'h10);
`ifdef LED_SEQ_IRQ_EN
    check("irq_clear", {31'b0, irq}, 32'd0);
`endif
    cpu_write(4'd0, 32'h0);

    // Waitrequest stall of 4 cycles, then EN cleared mid-write under stall
    cpu_write(4'd8, 32'h3C);
    cpu_write(4'd9, 32'hC3);
    cpu_write(4'd1, 32'd2);
    t = cyc;
    push(8'h3C, t + 6);
    push(8'hC3, t + 13);
    cpu_write(4'd0, 32'h1);
    goto(t + 2);
    m_waitrequest = 1'b1;
    goto(t + 6);
    m_waitrequest = 1'b0;
    goto(t + 10);
    m_waitrequest = 1'b1;
    goto(t + 11);
    cpu_write(4'd0, 32'h0);
    goto(t + 13);
    m_waitrequest = 1'b0;
    wait_drain("stop_drain", 20);
    idle(20);
    chk_read("stop_idle", 4'd2, 32'h00);

    // Length clamp: LENGTH=0 repeats table[0]
    cpu_write(4'd3, 32'd0);
    cpu_write(4'd1, 32'd0);
    t = cyc;
    push(8'h3C, t + 2);
    push(8'h3C, t + 4);
    push(8'h3C, t + 6);
    cpu_write(4'd0, 32'h1);
    goto(t + 6);
    cpu_write(4'd0, 32'h0);
    wait_drain("len0_drain", 20);
    idle(10);

    // Length clamp: LENGTH=15 walks all 8 entries then wraps
    for (int i = 0; i < 8; i++) cpu_write(4'(8 + i), 32'(8'h10 + i));
    cpu_write(4'd3, 32'd15);
    chk_read("len15_rb", 4'd3, 32'd15);
    t = cyc;
    for (int k = 0; k < 9; k++) push(8'(8'h10 + (k % 8)), t + 2 + 2 * k);
    cpu_write(4'd0, 32'h1);
    goto(t + 18);
    cpu_write(4'd0, 32'h0);
    wait_drain("len15_drain", 40);
    idle(10);

    // Reset during COUNT
    cpu_write(4'd1, 32'd5);
    t = cyc;
    push(8'h10, t + 2);
    cpu_write(4'd0, 32'h1);
    goto(t + 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_cs", {31'b0, m_chipselect}, 32'd0);
    check("mid_rst_wdata", m_writedata, 32'd0);
    chk_read("mid_rst_ctrl", 4'd0, 32'd0);
    chk_read("mid_rst_period", 4'd1, 32'd0);
    chk_read("mid_rst_status", 4'd2, 32'd0);
    chk_read("mid_rst_length", 4'd3, 32'd8);
    chk_read("mid_rst_tbl0", 4'd8, 32'd0);
    check("mid_rst_sb", 32'(sb.size()), 32'd0);
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
